// File: rtl/lb_prom_arb.sv
// Two-master round-robin arbiter for the SPI PROM LocalBus port, with per-master lock.
// Latency: request pulse -> PROM pulse two edges later on an idle bus; read data one cycle after prom_rd_rdy.
// Backpressure: none upstream; each master has a 1-deep pending buffer, and overflow drops the request and sets ovf.
//
// Ports: clk_lb/reset (async, active-high); mN_* master request/lock/read-return (N=0 host, N=1 on-chip);
//        prom_* shared PROM LocalBus port; busy/ovf status per master; ovf_clr clears sticky ovf.
// Optional feature: define LB_PROM_ARB_TIMEOUT_EN to force read completion with TO_DATA after TIMEOUT_CYC wait cycles.
module lb_prom_arb #(
    parameter int unsigned  TIMEOUT_CYC = 4096,
    parameter logic [31:0]  TO_DATA     = 32'hDEADBEEF
) (
    input  logic        clk_lb,
    input  logic        reset,
    input  logic        m0_wr,
    input  logic        m0_rd,
    input  logic [31:0] m0_addr,
    input  logic [31:0] m0_wr_d,
    input  logic        m0_lock,
    output logic [31:0] m0_rd_d,
    output logic        m0_rd_rdy,
    input  logic        m1_wr,
    input  logic        m1_rd,
    input  logic [31:0] m1_addr,
    input  logic [31:0] m1_wr_d,
    input  logic        m1_lock,
    output logic [31:0] m1_rd_d,
    output logic        m1_rd_rdy,
    output logic        prom_wr,
    output logic        prom_rd,
    output logic [31:0] prom_addr,
    output logic [31:0] prom_wr_d,
    input  logic [31:0] prom_rd_d,
    input  logic        prom_rd_rdy,
    output logic [1:0]  busy,
    output logic [1:0]  ovf,
    input  logic        ovf_clr
);

    typedef enum logic [1:0] {IDLE, ISSUE, RD_WAIT} state_t;

    state_t      state_q, state_d;

    logic [1:0]  in_wr, in_rd, in_lock;
    logic [31:0] in_addr [2];
    logic [31:0] in_dat  [2];

    logic [1:0]  pend_q, pend_wr_q;
    logic [31:0] pend_addr_q [2];
    logic [31:0] pend_dat_q  [2];

    logic        last_q;      // last granted master; doubles as lock owner
    logic        owned_q;     // set once any grant has happened, so lock has a real owner
    logic        prom_wr_q, prom_rd_q;
    logic [31:0] prom_addr_q, prom_wr_d_q;
    logic [1:0]  rd_rdy_q;
    logic [31:0] rd_d_q [2];
    logic [1:0]  ovf_q;

    logic        gnt_vld, gnt_idx;
    logic        rtn_vld;
    logic [31:0] rtn_dat;
    logic [1:0]  consumed, load_en, ovf_set;

    assign in_wr   = {m1_wr, m0_wr};
    assign in_rd   = {m1_rd, m0_rd};
    assign in_lock = {m1_lock, m0_lock};
    assign in_addr[0] = m0_addr;
    assign in_addr[1] = m1_addr;
    assign in_dat[0]  = m0_wr_d;
    assign in_dat[1]  = m1_wr_d;

`ifdef LB_PROM_ARB_TIMEOUT_EN
    logic [31:0] to_cnt_q;

    always_ff @(posedge clk_lb or posedge reset) begin
        if (reset) begin
            to_cnt_q <= '0;
        end else if (state_q == RD_WAIT) begin
            to_cnt_q <= to_cnt_q + 32'd1;
        end else begin
            to_cnt_q <= '0;
        end
    end
`else
    logic unused_cfg;
    assign unused_cfg = (TIMEOUT_CYC == 0) ^ (TO_DATA == 32'd0);
`endif

    // Next state, grant selection and read-return decision.
    always_comb begin
        state_d = state_q;
        gnt_vld = 1'b0;
        gnt_idx = last_q;
        rtn_vld = 1'b0;
        rtn_dat = prom_rd_d;
        case (state_q)
            IDLE: begin
                if (owned_q && in_lock[last_q]) begin
                    // Locked owner keeps the bus; the other master waits.
                    gnt_vld = pend_q[last_q];
                    gnt_idx = last_q;
                end else if (pend_q == 2'b11) begin
                    gnt_vld = 1'b1;
                    gnt_idx = ~last_q;
                end else if (pend_q[0]) begin
                    gnt_vld = 1'b1;
                    gnt_idx = 1'b0;
                end else if (pend_q[1]) begin
                    gnt_vld = 1'b1;
                    gnt_idx = 1'b1;
                end
                if (gnt_vld) begin
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                state_d = prom_rd_q ? RD_WAIT : IDLE;
            end
            RD_WAIT: begin
                if (prom_rd_rdy) begin
                    rtn_vld = 1'b1;
                    state_d = IDLE;
                end
`ifdef LB_PROM_ARB_TIMEOUT_EN
                else if (to_cnt_q == 32'(TIMEOUT_CYC - 1)) begin
                    rtn_vld = 1'b1;
                    rtn_dat = TO_DATA;
                    state_d = IDLE;
                end
`endif
            end
            default: state_d = IDLE;
        endcase
    end

    // Capture / drop decisions; a grant edge frees the buffer for a same-cycle request.
    always_comb begin
        consumed = '0;
        load_en  = '0;
        ovf_set  = '0;
        for (int n = 0; n < 2; n++) begin
            consumed[n] = gnt_vld && (gnt_idx == 1'(n));
            load_en[n]  = (in_wr[n] | in_rd[n]) & (~pend_q[n] | consumed[n]);
            ovf_set[n]  = (in_wr[n] & in_rd[n])
                        | ((in_wr[n] | in_rd[n]) & pend_q[n] & ~consumed[n]);
        end
    end

    always_ff @(posedge clk_lb or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk_lb or posedge reset) begin
        if (reset) begin
            pend_q      <= '0;
            pend_wr_q   <= '0;
            last_q      <= 1'b1;
            owned_q     <= 1'b0;
            prom_wr_q   <= 1'b0;
            prom_rd_q   <= 1'b0;
            prom_addr_q <= '0;
            prom_wr_d_q <= '0;
            rd_rdy_q    <= '0;
            ovf_q       <= '0;
            for (int n = 0; n < 2; n++) begin
                pend_addr_q[n] <= '0;
                pend_dat_q[n]  <= '0;
                rd_d_q[n]      <= '0;
            end
        end else begin
            prom_wr_q <= 1'b0;
            prom_rd_q <= 1'b0;
            rd_rdy_q  <= '0;
            if (gnt_vld) begin
                prom_wr_q   <= pend_wr_q[gnt_idx];
                prom_rd_q   <= ~pend_wr_q[gnt_idx];
                prom_addr_q <= pend_addr_q[gnt_idx];
                prom_wr_d_q <= pend_dat_q[gnt_idx];
                last_q      <= gnt_idx;
                owned_q     <= 1'b1;
            end
            if (rtn_vld) begin
                rd_rdy_q[last_q] <= 1'b1;
                rd_d_q[last_q]   <= rtn_dat;
            end
            for (int n = 0; n < 2; n++) begin
                if (load_en[n]) begin
                    pend_q[n]      <= 1'b1;
                    pend_wr_q[n]   <= in_wr[n];   // write wins a simultaneous wr+rd
                    pend_addr_q[n] <= in_addr[n];
                    pend_dat_q[n]  <= in_dat[n];
                end else if (consumed[n]) begin
                    pend_q[n] <= 1'b0;
                end
            end
            ovf_q <= (ovf_q & ~{2{ovf_clr}}) | ovf_set;
        end
    end

    assign prom_wr   = prom_wr_q;
    assign prom_rd   = prom_rd_q;
    assign prom_addr = prom_addr_q;
    assign prom_wr_d = prom_wr_d_q;
    assign m0_rd_d   = rd_d_q[0];
    assign m1_rd_d   = rd_d_q[1];
    assign m0_rd_rdy = rd_rdy_q[0];
    assign m1_rd_rdy = rd_rdy_q[1];
    assign busy      = pend_q;
    assign ovf       = ovf_q;

endmodule
